// File: rtl/riscv_defines.sv
// riscv_defines: shared privilege-level and interrupt-controller FSM types.
`default_nettype none

package riscv_defines;

  typedef enum logic [1:0] {
    PRIV_LVL_U = 2'b00,
    PRIV_LVL_S = 2'b01,
    PRIV_LVL_H = 2'b10,
    PRIV_LVL_M = 2'b11
  } PrivLvl_t;

  typedef enum logic [1:0] {
    IRQ_IDLE    = 2'd0,
    IRQ_PENDING = 2'd1,
    IRQ_DONE    = 2'd2
  } irq_ctrl_state_e;

endpackage

`default_nettype wire

// File: rtl/riscv_irq_prio_enc.sv
// riscv_irq_prio_enc: highest-index-wins priority encoder.
`default_nettype none

module riscv_irq_prio_enc #(
  parameter int NUM_IRQ = 32,
  localparam int ID_W = $clog2(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0] vec_i,
  output logic               valid_o,
  output logic [ID_W-1:0]    idx_o
);

  always_comb begin
    valid_o = |vec_i;
    idx_o   = '0;
    // Ascending scan: the last set bit seen is the highest index.
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (vec_i[i]) idx_o = ID_W'(i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/riscv_irq_prio_ctrl.sv
// riscv_irq_prio_ctrl: samples interrupt lines, picks a winner and hands it to the controller.
`default_nettype none

module riscv_irq_prio_ctrl
  import riscv_defines::*;
#(
  parameter int NUM_IRQ     = 32,
  parameter bit PULP_SECURE = 1'b0,
  localparam int ID_W = $clog2(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [NUM_IRQ-1:0] irq_en_i,
  input  logic [NUM_IRQ-1:0] irq_sec_i,
  input  logic               m_ie_i,
  input  logic               u_ie_i,
  input  PrivLvl_t           priv_lvl_i,
  input  logic               ctrl_ack_i,
  input  logic               ctrl_kill_i,
  output logic               irq_req_ctrl_o,
  output logic [ID_W-1:0]    irq_id_ctrl_o,
  output logic               irq_sec_ctrl_o,
  output logic [NUM_IRQ-1:0] irq_pending_o
);

  irq_ctrl_state_e    state_q, state_d;
  logic [NUM_IRQ-1:0] pending_q;
  logic [ID_W-1:0]    id_q, id_d;
  logic               sec_q, sec_d;

  logic [NUM_IRQ-1:0] cand;
  logic               win_valid;
  logic [ID_W-1:0]    win_idx;
  logic               win_sec;
  logic               gate;

  assign cand = pending_q & irq_en_i;

  riscv_irq_prio_enc #(
    .NUM_IRQ (NUM_IRQ)
  ) u_prio_enc (
    .vec_i   (cand),
    .valid_o (win_valid),
    .idx_o   (win_idx)
  );

  assign win_sec = irq_sec_i[win_idx];

  always_comb begin
    gate = m_ie_i;
    if (PULP_SECURE) begin
      // Secure lines may interrupt U mode even when U-mode interrupts are globally off.
      gate = ((u_ie_i | win_sec) & (priv_lvl_i == PRIV_LVL_U))
           | (m_ie_i & (priv_lvl_i == PRIV_LVL_M));
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    sec_d   = sec_q;
    unique case (state_q)
      IRQ_IDLE: begin
        if (win_valid && gate) begin
          id_d    = win_idx;
          sec_d   = win_sec;
          state_d = IRQ_PENDING;
        end
      end
      IRQ_PENDING: begin
        if (ctrl_ack_i) begin
          sec_d   = 1'b0;
          state_d = IRQ_DONE;
        end else if (ctrl_kill_i) begin
          state_d = IRQ_IDLE;
        end
      end
      IRQ_DONE: begin
        sec_d   = 1'b0;
        state_d = IRQ_IDLE;
      end
      default: begin
        state_d = IRQ_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IRQ_IDLE;
      pending_q <= '0;
      id_q      <= '0;
      sec_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= irq_i;
      id_q      <= id_d;
      sec_q     <= sec_d;
    end
  end

  assign irq_req_ctrl_o = (state_q == IRQ_PENDING);
  assign irq_id_ctrl_o  = id_q;
  assign irq_sec_ctrl_o = sec_q;
  assign irq_pending_o  = pending_q;

endmodule

`default_nettype wire

// File: tb/tb_riscv_irq_prio_ctrl.sv
// tb_riscv_irq_prio_ctrl: directed checks of latency, priority, ack/kill handling, secure gating and reset.
`default_nettype none

module tb_riscv_irq_prio_ctrl;
  import riscv_defines::*;

  localparam int N  = 32;
  localparam int IW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  irq, irq_en, irq_sec;
  logic          m_ie, u_ie, ack, kill;
  PrivLvl_t      priv;

  logic          req0, sec0, req1, sec1;
  logic [IW-1:0] id0, id1;
  logic [N-1:0]  pend0, pend1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  riscv_irq_prio_ctrl #(.NUM_IRQ(N), .PULP_SECURE(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .irq_i(irq), .irq_en_i(irq_en), .irq_sec_i(irq_sec),
    .m_ie_i(m_ie), .u_ie_i(u_ie), .priv_lvl_i(priv), .ctrl_ack_i(ack), .ctrl_kill_i(kill),
    .irq_req_ctrl_o(req0), .irq_id_ctrl_o(id0), .irq_sec_ctrl_o(sec0), .irq_pending_o(pend0)
  );

  riscv_irq_prio_ctrl #(.NUM_IRQ(N), .PULP_SECURE(1'b1)) dut_sec (
    .clk(clk), .rst_n(rst_n), .irq_i(irq), .irq_en_i(irq_en), .irq_sec_i(irq_sec),
    .m_ie_i(m_ie), .u_ie_i(u_ie), .priv_lvl_i(priv), .ctrl_ack_i(ack), .ctrl_kill_i(kill),
    .irq_req_ctrl_o(req1), .irq_id_ctrl_o(id1), .irq_sec_ctrl_o(sec1), .irq_pending_o(pend1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; irq = '0; irq_en = '1; irq_sec = '0;
    m_ie = 1'b1; u_ie = 1'b0; ack = 1'b0; kill = 1'b0; priv = PRIV_LVL_M;
    step(); step();
    chk("rst_req", 64'(req0), 64'd0);
    chk("rst_id", 64'(id0), 64'd0);
    chk("rst_sec", 64'(sec0), 64'd0);
    chk("rst_pend", 64'(pend0), 64'd0);
    chk("rst_req_s", 64'(req1), 64'd0);
    rst_n = 1'b1;
    step();

    // Single line 5: request two cycles after the edge, ack, one DONE cycle.
    irq = 32'h1 << 5;
    step();
    chk("lat_pend", 64'(pend0), 64'h20);
    chk("lat_req_c1", 64'(req0), 64'd0);
    step();
    chk("lat_req_c2", 64'(req0), 64'd1);
    chk("lat_id", 64'(id0), 64'd5);
    step();
    chk("hold_req_c3", 64'(req0), 64'd1);
    step();
    ack = 1'b1;
    step();
    ack = 1'b0; irq = '0;
    chk("done_req", 64'(req0), 64'd0);
    chk("done_sec", 64'(sec0), 64'd0);
    chk("done_id", 64'(id0), 64'd5);
    step();
    chk("idle_req_c6", 64'(req0), 64'd0);
    step();
    chk("idle_req_c7", 64'(req0), 64'd0);

    // Highest index wins and stays latched.
    irq = (32'h1 << 3) | (32'h1 << 17);
    step(); step();
    chk("prio_req", 64'(req0), 64'd1);
    chk("prio_id", 64'(id0), 64'd17);
    irq = irq | (32'h1 << 20);
    step(); step();
    chk("prio_hold_id", 64'(id0), 64'd17);
    irq = '0;
    step();
    chk("prio_hold_drop", 64'(id0), 64'd17);
    chk("prio_hold_req", 64'(req0), 64'd1);
    ack = 1'b1;
    step();
    ack = 1'b0;
    step(); step();
    chk("prio_idle", 64'(req0), 64'd0);

    // Ack and kill together: ack wins (DONE clears sec, then one idle cycle).
    irq_sec = 32'h1 << 12;
    irq = 32'h1 << 12;
    step(); step();
    chk("ak_req", 64'(req0), 64'd1);
    chk("ak_sec", 64'(sec0), 64'd1);
    ack = 1'b1; kill = 1'b1;
    step();
    ack = 1'b0; kill = 1'b0;
    chk("ak_done_req", 64'(req0), 64'd0);
    chk("ak_done_sec", 64'(sec0), 64'd0);
    step();
    chk("ak_idle_req", 64'(req0), 64'd0);
    step();
    chk("ak_rereq", 64'(req0), 64'd1);
    chk("ak_rereq_id", 64'(id0), 64'd12);
    irq = '0; kill = 1'b1;
    step();
    kill = 1'b0; irq_sec = '0;
    step();
    chk("ak_clean", 64'(req0), 64'd0);

    // Kill with line held: back to IDLE keeping ID, re-request next cycle.
    irq = 32'h1 << 9;
    step(); step();
    chk("kill_req", 64'(req0), 64'd1);
    kill = 1'b1;
    step();
    kill = 1'b0;
    chk("kill_idle_req", 64'(req0), 64'd0);
    chk("kill_keep_id", 64'(id0), 64'd9);
    step();
    chk("kill_rereq", 64'(req0), 64'd1);
    chk("kill_rereq_id", 64'(id0), 64'd9);
    irq = '0; ack = 1'b1;
    step();
    ack = 1'b0;
    step(); step();
    chk("kill_clean", 64'(req0), 64'd0);

    // Ack held high while idle must not block the next request.
    irq = 32'h1 << 2; ack = 1'b1;
    step(); step();
    chk("ackidle_req", 64'(req0), 64'd1);
    chk("ackidle_id", 64'(id0), 64'd2);
    irq = '0;
    step();
    ack = 1'b0;
    chk("ackidle_done", 64'(req0), 64'd0);
    step(); step();

    // Secure gating in U mode with u_ie off.
    priv = PRIV_LVL_U; m_ie = 1'b0; u_ie = 1'b0;
    irq_sec = 32'h1 << 7; irq = 32'h1 << 7;
    step(); step();
    chk("sec_req", 64'(req1), 64'd1);
    chk("sec_id", 64'(id1), 64'd7);
    chk("sec_bit", 64'(sec1), 64'd1);
    chk("nosec_mie_gate", 64'(req0), 64'd0);
    ack = 1'b1; irq = '0;
    step();
    ack = 1'b0;
    chk("sec_done_sec", 64'(sec1), 64'd0);
    step();
    irq_sec = '0; irq = 32'h1 << 7;
    step(); step();
    chk("nonsec_u_noreq", 64'(req1), 64'd0);
    step();
    chk("nonsec_u_noreq2", 64'(req1), 64'd0);
    irq = '0;
    step(); step();
    priv = PRIV_LVL_M; m_ie = 1'b1;

    // Asynchronous reset while pending.
    irq = 32'h1 << 30;
    step(); step();
    chk("pre_rst_req", 64'(req0), 64'd1);
    chk("pre_rst_id", 64'(id0), 64'd30);
    rst_n = 1'b0;
    #1;
    chk("arst_req", 64'(req0), 64'd0);
    chk("arst_id", 64'(id0), 64'd0);
    chk("arst_pend", 64'(pend0), 64'd0);
    step();
    rst_n = 1'b1; irq = '0;
    step();
    chk("post_rst_req", 64'(req0), 64'd0);
    chk("post_rst_id", 64'(id0), 64'd0);
    chk("post_rst_sec", 64'(sec0), 64'd0);
    chk("post_rst_pend", 64'(pend0), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/riscv_irq_prio_ctrl.md
RISCV_IRQ_PRIO_CTRL -- requirements
Module: riscv_irq_prio_ctrl

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 32, number of interrupt lines (range 2..64).
REQ-002 SHALL have parameter PULP_SECURE, default 0, which enables privilege-aware gating when set to 1.
REQ-003 SHALL have localparam ID_W = $clog2(NUM_IRQ), the width of the interrupt ID.
REQ-004 SHALL have port clk, input, 1, clock.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port irq_i, input, NUM_IRQ, level-triggered interrupt lines.
REQ-007 SHALL have port irq_en_i, input, NUM_IRQ, per-line enable mask (mie).
REQ-008 SHALL have port irq_sec_i, input, NUM_IRQ, per-line secure attribute.
REQ-009 SHALL have port m_ie_i, input, 1, global enable for M mode.
REQ-010 SHALL have port u_ie_i, input, 1, global enable for U mode.
REQ-011 SHALL have port priv_lvl_i, input, PrivLvl_t, current privilege level.
REQ-012 SHALL have port ctrl_ack_i, input, 1, controller accepted the request.
REQ-013 SHALL have port ctrl_kill_i, input, 1, controller dropped the request.
REQ-014 SHALL have port irq_req_ctrl_o, output, 1, request to controller.
REQ-015 SHALL have port irq_id_ctrl_o, output, ID_W, ID of the latched interrupt.
REQ-016 SHALL have port irq_sec_ctrl_o, output, 1, secure bit of the latched interrupt.
REQ-017 SHALL have port irq_pending_o, output, NUM_IRQ, registered mip view (irq_i sampled each cycle).

Function
REQ-018 SHALL register irq_i into pending_q every cycle; irq_pending_o = pending_q.
REQ-019 SHALL compute candidates = pending_q & irq_en_i.
REQ-020 SHALL select the highest-index set candidate bit as the winner.
REQ-021 With PULP_SECURE=0, SHALL gate the winner with m_ie_i only.
REQ-022 With PULP_SECURE=1, SHALL gate the winner with ((u_ie_i | winner_sec) & priv==U) | (m_ie_i & priv==M).
REQ-023 SHALL implement an FSM with states IDLE, PENDING and DONE.
REQ-024 In IDLE, with |candidates and the gate true, SHALL latch the winner ID and its irq_sec_i bit and move to PENDING next cycle.
REQ-025 SHALL drive irq_req_ctrl_o = 1 iff state == PENDING.
REQ-026 SHALL hold irq_id_ctrl_o and irq_sec_ctrl_o stable throughout PENDING, even if irq_i deasserts or a higher-priority line arrives.
REQ-027 In PENDING, ctrl_ack_i SHALL move the FSM to DONE; ack has priority over a simultaneous kill.
REQ-028 In PENDING, ctrl_kill_i without ack SHALL move the FSM to IDLE and keep the ID.
REQ-029 In PENDING with neither ack nor kill, SHALL remain in PENDING.
REQ-030 DONE SHALL last exactly one cycle, clear irq_sec_ctrl_o to 0 and return to IDLE; irq_id_ctrl_o SHALL retain its last value.
REQ-031 SHALL ignore ack and kill outside PENDING.
REQ-032 Latency from irq_i rising to irq_req_ctrl_o SHALL be 2 cycles: sample, then latch.
REQ-033 After DONE, an interrupt still asserted SHALL be able to re-request, with at least 1 IDLE cycle between requests.

Reset
REQ-034 On rst_n low, state = IDLE, pending_q = 0, irq_id_ctrl_o = 0, irq_sec_ctrl_o = 0 and irq_req_ctrl_o = 0, asynchronously and mid-operation included.
REQ-035 SHALL drop irq_req_ctrl_o in the same cycle that reset is asserted.

Structure
REQ-036 PrivLvl_t and the FSM state enum irq_ctrl_state_e SHALL live in riscv_defines.
REQ-037 The priority encoder SHALL be the sub-module riscv_irq_prio_enc (parameter NUM_IRQ; outputs valid and idx).
REQ-038 SHALL use nonblocking assignments only in sequential logic, with a single always_ff.

Verification
REQ-039 NUM_IRQ=32, m_ie=1, irq_en=all ones, irq_i[5]=1 at cycle 0 -> req=1 at cycle 2 with id=5; ack at cycle 4 -> DONE at cycle 5, IDLE at cycle 6.
REQ-040 irq_i[3] and irq_i[17] asserted together -> id=17; irq_i[20] then raised during PENDING -> id stays 17.
REQ-041 ack and kill asserted in the same PENDING cycle -> next state DONE.
REQ-042 kill while PENDING on id=9 with irq_i[9] held -> IDLE, then re-request for id=9 two cycles later.
REQ-043 PULP_SECURE=1, priv=U, u_ie=0, irq_i[7]=1, irq_sec_i[7]=1 -> req with sec=1; with irq_sec_i[7]=0 -> no req.
REQ-044 rst_n dropped while PENDING -> req=0 immediately; all outputs at 0 after release.
